// File: rtl/branch_cond_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : branch_cond_unit                                           |
// | Description : Conditional-branch resolver. Holds a branch request from   |
// |               decode until the ALU flags are committed, then evaluates   |
// |               the condition and issues a PC redirect (taken) or reports  |
// |               fall-through (not taken).                                  |
// | Option      : BRCU_STATS_EN adds saturating taken/not-taken counters.     |
// | Ports       : clk, reset (async, active-high)                            |
// |               br_valid_i/br_ready_o, br_cond_i, br_pc_i, br_offset_i     |
// |               flags_pending_i, z_i, n_i, v_i  (status register flags)    |
// |               redir_valid_o/redir_ready_i, redir_pc_o, flush_o           |
// |               done_o, taken_o, [taken_cnt_o, nottaken_cnt_o]             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module branch_cond_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid_i,
  output logic              br_ready_o,
  input  logic [3:0]        br_cond_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [ADDR_W-1:0] br_offset_i,
  input  logic              flags_pending_i,
  input  logic              z_i,
  input  logic              n_i,
  input  logic              v_i,
  output logic              redir_valid_o,
  input  logic              redir_ready_i,
  output logic [ADDR_W-1:0] redir_pc_o,
  output logic              flush_o,
  output logic              done_o,
  output logic              taken_o
`ifdef BRCU_STATS_EN
  ,
  output logic [15:0]       taken_cnt_o,
  output logic [15:0]       nottaken_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cond_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   offset_q;
  logic [ADDR_W-1:0]   redir_pc_q;
  logic                taken_q;
  logic                done_q;

  logic                w_accept;
  logic                w_eval;
  logic                w_cond_true;
  logic [ADDR_W-1:0]   w_target;
  logic [ADDR_W-1:0]   w_fallthru;

  assign w_accept = (state_q == S_IDLE) && br_valid_i;
  // Flags are only trusted in the first WAIT cycle without a pending writer.
  assign w_eval   = (state_q == S_WAIT) && !flags_pending_i;

  // Offset counts words; the shift drops the top two bits (silent wrap).
  assign w_target   = pc_q + (offset_q << 2);
  assign w_fallthru = pc_q + ADDR_W'(4);

  always_comb begin
    w_cond_true = 1'b0;
    case (cond_q)
      4'b0000: w_cond_true = z_i;
      4'b0001: w_cond_true = !z_i;
      4'b0010: w_cond_true = n_i;
      4'b0011: w_cond_true = !n_i;
      4'b0100: w_cond_true = v_i;
      4'b0101: w_cond_true = !v_i;
      4'b0110: w_cond_true = n_i ^ v_i;
      4'b0111: w_cond_true = !(n_i ^ v_i);
      4'b1000: w_cond_true = !z_i && !(n_i ^ v_i);
      4'b1001: w_cond_true = z_i || (n_i ^ v_i);
      4'b1110: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (br_valid_i) state_d = S_WAIT;
      S_WAIT:     if (!flags_pending_i) state_d = w_cond_true ? S_REDIRECT : S_IDLE;
      S_REDIRECT: if (redir_ready_i) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cond_q     <= 4'd0;
      pc_q       <= '0;
      offset_q   <= '0;
      redir_pc_q <= '0;
      taken_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= w_eval;
      if (w_accept) begin
        cond_q   <= br_cond_i;
        pc_q     <= br_pc_i;
        offset_q <= br_offset_i;
      end
      if (w_eval) begin
        taken_q    <= w_cond_true;
        redir_pc_q <= w_cond_true ? w_target : w_fallthru;
      end
    end
  end

  assign br_ready_o    = (state_q == S_IDLE);
  assign redir_valid_o = (state_q == S_REDIRECT);
  assign flush_o       = redir_valid_o && redir_ready_i;
  assign redir_pc_o    = redir_pc_q;
  assign taken_o       = taken_q;
  assign done_o        = done_q;

`ifdef BRCU_STATS_EN
  logic [15:0] taken_cnt_q;
  logic [15:0] nottaken_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt_q    <= 16'd0;
      nottaken_cnt_q <= 16'd0;
    end else if (w_eval) begin
      if (w_cond_true) begin
        if (taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
      end else begin
        if (nottaken_cnt_q != 16'hFFFF) nottaken_cnt_q <= nottaken_cnt_q + 16'd1;
      end
    end
  end

  assign taken_cnt_o    = taken_cnt_q;
  assign nottaken_cnt_o = nottaken_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_branch_cond_unit                                        |
// | Description : Self-checking bench for branch_cond_unit: directed vector  |
// |               table, randomized branches against a reference model, and |
// |               hand-written reset/idle sequences. BRCU_STATS_EN enables  |
// |               the counter checks.                                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_branch_cond_unit;

  logic        clk;
  logic        reset;
  logic        br_valid;
  logic        br_ready;
  logic [3:0]  br_cond;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        flags_pending;
  logic        z, n, v;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic        flush;
  logic        done;
  logic        taken;
`ifdef BRCU_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] nottaken_cnt;
`endif

  branch_cond_unit #(.ADDR_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .br_valid_i      (br_valid),
    .br_ready_o      (br_ready),
    .br_cond_i       (br_cond),
    .br_pc_i         (br_pc),
    .br_offset_i     (br_offset),
    .flags_pending_i (flags_pending),
    .z_i             (z),
    .n_i             (n),
    .v_i             (v),
    .redir_valid_o   (redir_valid),
    .redir_ready_i   (redir_ready),
    .redir_pc_o      (redir_pc),
    .flush_o         (flush),
    .done_o          (done),
    .taken_o         (taken)
`ifdef BRCU_STATS_EN
    ,
    .taken_cnt_o     (taken_cnt),
    .nottaken_cnt_o  (nottaken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cond;
    logic [31:0] pc;
    logic [31:0] off;
    logic        z, n, v;
    int          pend;
    int          rdly;
    logic        exp_taken;
    logic [31:0] exp_pc;
    string       name;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  int ref_taken = 0;
  int ref_nt    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: condition truth from the flags' arithmetic meaning.
  function automatic logic ref_cond(input logic [3:0] c, input logic fz, fn, fv);
    logic signed_lt;
    signed_lt = (fn != fv);   // result < 0 as signed, overflow-corrected
    case (c)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fn;
      4'd3:  return !fn;
      4'd4:  return fv;
      4'd5:  return !fv;
      4'd6:  return signed_lt;
      4'd7:  return !signed_lt;
      4'd8:  return !fz && !signed_lt;
      4'd9:  return fz || signed_lt;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic run(input vec_t t);
    int k;
    logic [31:0] hold_pc;
    k = 0;
    while (!br_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check({t.name, "_ready_before"}, {31'd0, br_ready}, 32'd1);
    br_valid = 1'b1; br_cond = t.cond; br_pc = t.pc; br_offset = t.off;
    flags_pending = 1'b0; z = ~t.z; n = ~t.n; v = ~t.v;
    @(posedge clk); #1;
    check({t.name, "_ready_low_in_wait"}, {31'd0, br_ready}, 32'd0);
    // Keep br_valid high with junk request data: must be ignored outside IDLE.
    br_pc = ~t.pc; br_cond = ~t.cond; br_offset = ~t.off;
    for (int i = 0; i < t.pend; i++) begin
      flags_pending = 1'b1; z = ~t.z; n = ~t.n; v = ~t.v;
      @(posedge clk); #1;
      check({t.name, "_no_done_pending"}, {31'd0, done}, 32'd0);
    end
    flags_pending = 1'b0; z = t.z; n = t.n; v = t.v;
    redir_ready = (t.rdly == 0);
    @(posedge clk); #1;
    br_valid = 1'b0;
    z = ~t.z; n = ~t.n; v = ~t.v;   // later flag changes must not matter
    if (t.exp_taken) ref_taken++; else ref_nt++;
    check({t.name, "_done"},        {31'd0, done},        32'd1);
    check({t.name, "_taken"},       {31'd0, taken},       {31'd0, t.exp_taken});
    check({t.name, "_redir_pc"},    redir_pc,             t.exp_pc);
    check({t.name, "_redir_valid"}, {31'd0, redir_valid}, {31'd0, t.exp_taken});
    if (t.exp_taken) begin
      hold_pc = t.exp_pc;
      if (t.rdly > 0) begin
        for (int i = 0; i < t.rdly; i++) begin
          check({t.name, "_no_flush_bp"}, {31'd0, flush}, 32'd0);
          @(posedge clk); #1;
          check({t.name, "_valid_held"}, {31'd0, redir_valid}, 32'd1);
          check({t.name, "_pc_held"},    redir_pc,             hold_pc);
          check({t.name, "_taken_held"}, {31'd0, taken},       32'd1);
        end
        redir_ready = 1'b1; #1;
      end
      check({t.name, "_flush"}, {31'd0, flush}, 32'd1);
      @(posedge clk); #1;
      redir_ready = 1'b0;
      check({t.name, "_idle_after_flush"}, {31'd0, br_ready},    32'd1);
      check({t.name, "_valid_dropped"},    {31'd0, redir_valid}, 32'd0);
      check({t.name, "_done_one_cycle"},   {31'd0, done},        32'd0);
    end else begin
      check({t.name, "_ready_with_done"}, {31'd0, br_ready}, 32'd1);
      check({t.name, "_no_flush"},        {31'd0, flush},    32'd0);
      redir_ready = 1'b0;
    end
  endtask

  vec_t tbl[12];

  initial begin
    vec_t r;
    logic [31:0] rpc, roff;
    logic        rt;
    br_valid = 0; br_cond = 0; br_pc = 0; br_offset = 0;
    flags_pending = 0; z = 0; n = 0; v = 0; redir_ready = 0;

    tbl[0]  = '{4'b0000, 32'h100,      32'h4,        1,0,0, 0,0, 1, 32'h110,      "eq_taken"};
    tbl[1]  = '{4'b0001, 32'h200,      32'h7,        1,0,0, 0,0, 0, 32'h204,      "ne_not"};
    tbl[2]  = '{4'b1110, 32'h0,        32'hFFFFFFFF, 0,0,0, 0,4, 1, 32'hFFFFFFFC, "al_wrap_bp"};
    tbl[3]  = '{4'b1111, 32'hFFFFFFFC, 32'h10,       1,1,1, 0,0, 0, 32'h0,        "nv_wrap"};
    tbl[4]  = '{4'b0110, 32'h300,      32'hFFFFFFFE, 0,1,0, 0,0, 1, 32'h2F8,      "lt_taken"};
    tbl[5]  = '{4'b0111, 32'h300,      32'hFFFFFFFE, 0,1,0, 0,0, 0, 32'h304,      "ge_not"};
    tbl[6]  = '{4'b0000, 32'h400,      32'h3,        1,0,0, 3,0, 1, 32'h40C,      "eq_hazard"};
    tbl[7]  = '{4'b1000, 32'h500,      32'h10,       0,0,0, 0,1, 1, 32'h540,      "gt_taken"};
    tbl[8]  = '{4'b1001, 32'h500,      32'h10,       0,1,1, 0,0, 0, 32'h504,      "le_not"};
    tbl[9]  = '{4'b1010, 32'h10,       32'h1,        1,1,1, 0,0, 0, 32'h14,       "rsv_not"};
    tbl[10] = '{4'b0100, 32'h20,       32'h2,        0,0,1, 1,0, 1, 32'h28,       "vs_taken"};
    tbl[11] = '{4'b0010, 32'h30,       32'h5,        0,0,1, 0,0, 0, 32'h34,       "mi_not"};

    reset = 1'b1;
    #12;
    check("rst_ready",       {31'd0, br_ready},    32'd1);
    check("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    check("rst_redir_pc",    redir_pc,             32'd0);
    check("rst_done",        {31'd0, done},        32'd0);
    check("rst_taken",       {31'd0, taken},       32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // redir_ready with nothing to redirect does nothing.
    redir_ready = 1'b1; #1;
    check("idle_ready_no_flush", {31'd0, flush}, 32'd0);
    @(posedge clk); #1;
    check("idle_ready_stays_idle", {31'd0, br_ready}, 32'd1);
    redir_ready = 1'b0;

    for (int i = 0; i < 12; i++) run(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      r.cond = 4'($urandom_range(0, 15));
      rpc = $urandom; roff = $urandom;
      if (i % 4 == 0) roff = 32'hC0000000 | roff;   // exercise wrap
      r.pc = rpc; r.off = roff;
      r.z = 1'($urandom); r.n = 1'($urandom); r.v = 1'($urandom);
      r.pend = $urandom_range(0, 2);
      r.rdly = $urandom_range(0, 2);
      rt = ref_cond(r.cond, r.z, r.n, r.v);
      r.exp_taken = rt;
      r.exp_pc = rt ? rpc + roff * 32'd4 : rpc + 32'd4;
      r.name = "rand";
      run(r);
    end

`ifdef BRCU_STATS_EN
    check("stats_taken",    {16'd0, taken_cnt},    32'(ref_taken));
    check("stats_nottaken", {16'd0, nottaken_cnt}, 32'(ref_nt));
`endif

    // Reset while a redirect is outstanding and fetch is ready.
    br_valid = 1'b1; br_cond = 4'b1110; br_pc = 32'h800; br_offset = 32'h1;
    @(posedge clk); #1;
    br_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_redirect", {31'd0, redir_valid}, 32'd1);
    redir_ready = 1'b1;
    reset = 1'b1; #1;
    check("mid_rst_valid", {31'd0, redir_valid}, 32'd0);
    check("mid_rst_flush", {31'd0, flush},       32'd0);
    check("mid_rst_ready", {31'd0, br_ready},    32'd1);
    check("mid_rst_done",  {31'd0, done},        32'd0);
    check("mid_rst_pc",    redir_pc,             32'd0);
`ifdef BRCU_STATS_EN
    check("mid_rst_cnt",   {16'd0, taken_cnt},   32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0; redir_ready = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {31'd0, br_ready}, 32'd1);

`ifdef BRCU_STATS_EN
    begin
      int cnt, cyc;
      cnt = 0; cyc = 0;
      br_valid = 1'b1; br_cond = 4'b1110; br_pc = 32'h0; br_offset = 32'h0;
      redir_ready = 1'b1; flags_pending = 1'b0;
      while (cnt < 70000 && cyc < 300000) begin
        @(posedge clk); #1;
        cyc++;
        if (done) cnt++;
      end
      br_valid = 1'b0;
      check("sat_done_count", 32'(cnt), 32'd70000);
      repeat (4) @(posedge clk);
      #1;
      check("sat_taken_cnt",    {16'd0, taken_cnt},    32'h0000FFFF);
      check("sat_nottaken_cnt", {16'd0, nottaken_cnt}, 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_cond_unit.md
# branch_cond_unit

Conditional-branch resolver sitting directly downstream of the status register. It accepts a branch request from decode and holds it until the Z/N/V flags produced by the ALU have been committed to the status register. It then evaluates the branch condition and either issues a PC redirect/flush to fetch, or reports fall-through.

## Interface
- ADDR_W, 32, width of PC, offset and target buses.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- br_valid  in  1  branch request valid.
- br_ready  out  1  unit can accept a request; high only in IDLE.
- br_cond  in  4  condition code (encoding below).
- br_pc  in  ADDR_W  address of the branch instruction.
- br_offset  in  ADDR_W  signed word offset.
- flags_pending  in  1  a flag-writing ALU op is in flight; Z/N/V not yet valid.
- Z, N, V  in  1 each  committed flags from the status register.
- redir_valid  out  1  taken-branch redirect valid.
- redir_ready  in  1  fetch accepts the redirect.
- redir_pc  out  ADDR_W  resolved next PC (target or fall-through).
- flush  out  1  high when redir_valid && redir_ready (combinational).
- done  out  1  one-cycle pulse per resolved branch.
- taken  out  1  resolution result; valid while done or redir_valid is high.
- taken_cnt, nottaken_cnt  out  16 each  statistics; present only with BRCU_STATS_EN.

## Operation
- Condition encoding:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 MI: N
  - 0011 PL: !N
  - 0100 VS: V
  - 0101 VC: !V
  - 0110 LT: N!=V
  - 0111 GE: N==V
  - 1000 GT: !Z && N==V
  - 1001 LE: Z || N!=V
  - 1110 AL: always taken
  - 1010-1101 and 1111: never taken
- FSM states: IDLE, WAIT, REDIRECT.
  - IDLE: when br_valid && br_ready, latch cond/pc/offset and go to WAIT.
  - WAIT: while flags_pending=1, stay in WAIT. When flags_pending=0, evaluate against the current Z/N/V.
    - Taken: go to REDIRECT.
    - Not taken: go to IDLE.
  - REDIRECT: hold redir_valid=1 with redir_pc/taken stable until redir_ready=1, then go to IDLE.
- Arithmetic, all mod 2^ADDR_W, wrap-around silent:
  - Taken target = pc + (offset << 2).
  - Fall-through = pc + 4.
- Outputs are registered at evaluation:
  - done=1 for exactly one cycle.
  - redir_pc loaded with the target or fall-through.
  - taken loaded with the result.
- For a not-taken branch, redir_valid stays 0 and redir_pc = fall-through (informational only).
- Flags are sampled only in the evaluation cycle. Flag changes before or after that cycle are ignored.
- Reset, asynchronous, from any state:
  - State returns to IDLE and the latched request is discarded.
  - redir_valid=0, redir_pc=0, done=0, taken=0.
  - flush=0; br_ready=1 (IDLE).
  - Counters cleared.

## Timing
- Request accepted at edge T; the unit is in WAIT during cycle T+1.
- With flags_pending=0 in T+1, evaluation happens at edge T+2:
  - done=1 during T+2.
  - If taken, redir_valid=1 from T+2.
- Each cycle of flags_pending=1 in WAIT adds one cycle of latency.
- Taken branch: flush is high in the cycle redir_ready is seen with redir_valid. The unit is back in IDLE, and br_ready=1, on the next cycle.
- Not-taken branch: br_ready=1 in the cycle done is high. Throughput is one branch per 2 cycles.
- redir_ready asserted while redir_valid=0 has no effect.
- br_valid is ignored outside IDLE.

## Configuration
- BRCU_STATS_EN defined:
  - Adds taken_cnt and nottaken_cnt.
  - The matching counter increments by 1 at each evaluation edge and saturates at 0xFFFF.
  - Both counters clear on reset.
- BRCU_STATS_EN undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan
- Taken EQ: Z=1, cond=0000, pc=0x100, offset=4.
  - Expect done and redir_valid 2 cycles after accept, redir_pc=0x110, taken=1.
  - With redir_ready=1: flush pulses once, then br_ready=1.
- Not-taken NE: Z=1, cond=0001, pc=0x200.
  - Expect done=1, taken=0, redir_pc=0x204, redir_valid never asserted.
- Flag hazard: flags_pending=1 for 3 cycles after accept, with Z toggling 0→1 at the release cycle, cond=EQ.
  - Expect evaluation exactly at release using Z=1: done 5 cycles after accept, taken=1.
- Backpressure and wrap: redir_ready=0 for 4 cycles.
  - Expect redir_valid/redir_pc/taken stable, no flush until redir_ready=1.
  - pc=0, offset=0xFFFFFFFF, AL: redir_pc=0xFFFFFFFC.
  - pc=0xFFFFFFFC, NV: redir_pc=0x0.
- Signed conditions: N=1, V=0, cond=LT → taken; same flags with GE → not taken.
- Reset and stats:
  - Reset asserted mid-REDIRECT → redir_valid=0 immediately, br_ready=1, no flush.
  - With BRCU_STATS_EN: 70000 taken branches → taken_cnt=0xFFFF.
